// File: rtl/bypass_lane_driver_pkg.sv
// ---------------------------------------------------------------------------
// bypass_lane_driver_pkg
// Shared core definitions for the bypass network. The producer lane drivers
// and the source-operand bypass muxes both use these.
//   DEFAULT_SIZE_PHYSICAL_LOG : physical register tag width
//   DEFAULT_SIZE_DATA         : result data width
//   DEFAULT_Q_DEPTH           : default slow-result FIFO depth
//   bypassPkt                 : {valid, tag, data} bypass slot
// ---------------------------------------------------------------------------
package bypass_lane_driver_pkg;

  localparam int DEFAULT_SIZE_PHYSICAL_LOG = 7;
  localparam int DEFAULT_SIZE_DATA         = 32;
  localparam int DEFAULT_Q_DEPTH           = 4;

  typedef struct packed {
    logic                                 valid;
    logic [DEFAULT_SIZE_PHYSICAL_LOG-1:0] tag;
    logic [DEFAULT_SIZE_DATA-1:0]         data;
  } bypassPkt;

  // Width of an occupancy count that can represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bypass_lane_driver_if.sv
// ---------------------------------------------------------------------------
// bypass_lane_driver_if
// Groups one lane's result inputs, slow-path handshake and bypass slot output.
//   slave  : the lane driver (consumes results, drives bypass slot)
//   master : execution side / environment (offers results)
// ---------------------------------------------------------------------------
interface bypass_lane_driver_if #(
  parameter int SIZE_PHYSICAL_LOG = bypass_lane_driver_pkg::DEFAULT_SIZE_PHYSICAL_LOG,
  parameter int SIZE_DATA         = bypass_lane_driver_pkg::DEFAULT_SIZE_DATA,
  parameter int Q_DEPTH           = bypass_lane_driver_pkg::DEFAULT_Q_DEPTH
);
  import bypass_lane_driver_pkg::*;

  logic                         squash_i;
  logic                         fastValid_i;
  logic [SIZE_PHYSICAL_LOG-1:0] fastTag_i;
  logic [SIZE_DATA-1:0]         fastData_i;
  logic                         slowValid_i;
  logic                         slowReady_o;
  logic [SIZE_PHYSICAL_LOG-1:0] slowTag_i;
  logic [SIZE_DATA-1:0]         slowData_i;
  bypassPkt                     bypassPacket_o;
  logic [$clog2(Q_DEPTH):0]     occupancy_o;

  modport slave (
    input  squash_i, fastValid_i, fastTag_i, fastData_i,
    input  slowValid_i, slowTag_i, slowData_i,
    output slowReady_o, bypassPacket_o, occupancy_o
  );

  modport master (
    output squash_i, fastValid_i, fastTag_i, fastData_i,
    output slowValid_i, slowTag_i, slowData_i,
    input  slowReady_o, bypassPacket_o, occupancy_o
  );

endinterface

// File: rtl/bypass_result_fifo.sv
// ---------------------------------------------------------------------------
// bypass_result_fifo
// Circular buffer holding variable-latency results until an idle bypass slot.
//   clk, reset    : clock, async active-low reset
//   clear         : synchronous flush (pointers and count to zero)
//   push          : write {push_tag, push_data} at tail (ignored when full)
//   pop           : advance head (ignored when empty)
//   head_tag/data : oldest entry
//   count         : entries held; full / empty flags derived from it
// ---------------------------------------------------------------------------
module bypass_result_fifo #(
  parameter int Q_DEPTH = 4,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic [DATA_W-1:0]          push_data,
  output logic [TAG_W-1:0]           head_tag,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(Q_DEPTH):0]   count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(Q_DEPTH);

  logic [TAG_W+DATA_W-1:0] mem [Q_DEPTH];
  logic [PTR_W-1:0]        head_ptr;
  logic [PTR_W-1:0]        tail_ptr;
  logic [CNT_W-1:0]        count_r;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (count_r == DEPTH_CNT);
  assign empty   = (count_r == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_r  <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + 1'b1;
      if (pop_ok)  head_ptr <= head_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[tail_ptr] <= {push_tag, push_data};
  end

  assign {head_tag, head_data} = mem[head_ptr];
  assign count = count_r;

endmodule

// File: rtl/bypass_lane_driver.sv
// ---------------------------------------------------------------------------
// bypass_lane_driver
// Drives one registered bypass packet per cycle for a single issue lane.
// Fast (fixed-latency) results win the slot; slow results queue in a FIFO and
// drain into cycles with no fast result. Squash flushes everything.
//   clk    : clock
//   reset  : async active-low reset
//   bus    : bypass_lane_driver_if.slave (results in, handshake, packet out)
// ---------------------------------------------------------------------------
module bypass_lane_driver
  import bypass_lane_driver_pkg::*;
#(
  parameter int SIZE_PHYSICAL_LOG = bypass_lane_driver_pkg::DEFAULT_SIZE_PHYSICAL_LOG,
  parameter int SIZE_DATA         = bypass_lane_driver_pkg::DEFAULT_SIZE_DATA,
  parameter int Q_DEPTH           = bypass_lane_driver_pkg::DEFAULT_Q_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  bypass_lane_driver_if.slave  bus
);

  localparam int CNT_W = occ_width(Q_DEPTH);

  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic [SIZE_PHYSICAL_LOG-1:0] head_tag;
  logic [SIZE_DATA-1:0]         head_data;
  logic [CNT_W-1:0]             count;
  bypassPkt                     pkt_next;
  bypassPkt                     pkt_p0;

  // Squash drops any offered slow result; the FIFO only drains into slots
  // that the fast path leaves idle.
  assign push = bus.slowValid_i && !full && !bus.squash_i;
  assign pop  = !bus.squash_i && !bus.fastValid_i && !empty;

  bypass_result_fifo #(
    .Q_DEPTH (Q_DEPTH),
    .TAG_W   (SIZE_PHYSICAL_LOG),
    .DATA_W  (SIZE_DATA)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.squash_i),
    .push      (push),
    .pop       (pop),
    .push_tag  (bus.slowTag_i),
    .push_data (bus.slowData_i),
    .head_tag  (head_tag),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Invalid packets carry zero tag/data so no consumer can match a stale tag.
  always_comb begin
    pkt_next = '0;
    if (!bus.squash_i) begin
      if (bus.fastValid_i) begin
        pkt_next.valid = 1'b1;
        pkt_next.tag   = bus.fastTag_i;
        pkt_next.data  = bus.fastData_i;
      end else if (!empty) begin
        pkt_next.valid = 1'b1;
        pkt_next.tag   = head_tag;
        pkt_next.data  = head_data;
      end
    end
  end

  // ---- output register (stage p0) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pkt_p0 <= '0;
    else        pkt_p0 <= pkt_next;
  end

  assign bus.bypassPacket_o = pkt_p0;
  assign bus.slowReady_o    = !full;
  assign bus.occupancy_o    = count;

endmodule

// File: tb/tb_bypass_lane_driver.sv
// ---------------------------------------------------------------------------
// tb_bypass_lane_driver
// Directed and randomized stimulus for bypass_lane_driver, checked against a
// queue-based reference model of the lane's result selection.
// ---------------------------------------------------------------------------
module tb_bypass_lane_driver;
  import bypass_lane_driver_pkg::*;

  localparam int QD = 4;

  logic clk = 1'b0;
  logic reset;

  bypass_lane_driver_if #(.SIZE_PHYSICAL_LOG(7), .SIZE_DATA(32), .Q_DEPTH(QD)) bus();

  bypass_lane_driver #(.SIZE_PHYSICAL_LOG(7), .SIZE_DATA(32), .Q_DEPTH(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as {tag, data} in arrival order.
  logic [38:0] q[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.squash_i    = 1'b0;
    bus.fastValid_i = 1'b0;
    bus.fastTag_i   = '0;
    bus.fastData_i  = '0;
    bus.slowValid_i = 1'b0;
    bus.slowTag_i   = '0;
    bus.slowData_i  = '0;
  endtask

  // One clock: predict from current inputs and model, advance, then compare.
  task automatic step(input string name, output bit accepted);
    logic [39:0] exp_pkt;
    exp_pkt  = '0;
    accepted = bus.slowValid_i && (q.size() < QD) && !bus.squash_i;
    if (!bus.squash_i) begin
      if (bus.fastValid_i)  exp_pkt = {1'b1, bus.fastTag_i, bus.fastData_i};
      else if (q.size() > 0) exp_pkt = {1'b1, q[0]};
    end
    @(posedge clk);
    if (bus.squash_i) q.delete();
    else begin
      if (!bus.fastValid_i && q.size() > 0) void'(q.pop_front());
      if (accepted) q.push_back({bus.slowTag_i, bus.slowData_i});
    end
    #1;
    chk({name, ".pkt"}, 64'(bus.bypassPacket_o), 64'(exp_pkt));
    chk({name, ".occ"}, 64'(bus.occupancy_o), 64'(q.size()));
    chk({name, ".rdy"}, 64'(bus.slowReady_o), 64'(q.size() < QD));
  endtask

  initial begin
    bit acc;
    bit got;

    // Reset state
    reset = 1'b0;
    idle();
    #7;
    chk("rst.pkt", 64'(bus.bypassPacket_o), 64'h0);
    chk("rst.occ", 64'(bus.occupancy_o), 64'd0);
    chk("rst.rdy", 64'(bus.slowReady_o), 64'd1);
    #5 reset = 1'b1;

    // Fast result: one-cycle latency, then invalid
    bus.fastValid_i = 1'b1;
    bus.fastTag_i   = 7'd5;
    bus.fastData_i  = 32'hAAAA;
    step("fast1", acc);
    chk("fast1.exact", 64'(bus.bypassPacket_o), {24'h0, 1'b1, 7'd5, 32'hAAAA});
    idle();
    step("fast1_after", acc);
    chk("fast1_after.exact", 64'(bus.bypassPacket_o), 64'h0);

    // Slow result: two-cycle latency through the FIFO
    bus.slowValid_i = 1'b1;
    bus.slowTag_i   = 7'd9;
    bus.slowData_i  = 32'h1234;
    step("slow1", acc);
    chk("slow1.acc", 64'(acc), 64'd1);
    chk("slow1.occ1", 64'(bus.occupancy_o), 64'd1);
    idle();
    step("slow1_out", acc);
    chk("slow1_out.exact", 64'(bus.bypassPacket_o), {24'h0, 1'b1, 7'd9, 32'h1234});
    chk("slow1_out.occ0", 64'(bus.occupancy_o), 64'd0);

    // Fill FIFO under continuous fast traffic
    for (int i = 0; i < 4; i++) begin
      bus.fastValid_i = 1'b1;
      bus.fastTag_i   = 7'(100 + i);
      bus.fastData_i  = $urandom;
      bus.slowValid_i = 1'b1;
      bus.slowTag_i   = 7'(20 + i);
      bus.slowData_i  = 32'(32'hC000 + i);
      step("fill", acc);
      chk("fill.acc", 64'(acc), 64'd1);
    end
    bus.fastTag_i   = 7'd104;
    bus.slowTag_i   = 7'd24;
    bus.slowData_i  = 32'hC004;
    chk("full.rdy0", 64'(bus.slowReady_o), 64'd0);
    step("full_fast", acc);
    chk("full_fast.acc", 64'(acc), 64'd0);

    // Full with a dequeue and an offer in the same cycle: offer refused
    bus.fastValid_i = 1'b0;
    step("full_deq", acc);
    chk("full_deq.acc", 64'(acc), 64'd0);
    chk("full_deq.occ3", 64'(bus.occupancy_o), 64'd3);
    chk("full_deq.rdy1", 64'(bus.slowReady_o), 64'd1);
    chk("drain.tag20", 64'(bus.bypassPacket_o.tag), 64'd20);
    got = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step("drain", acc);
      if (acc) begin
        got = 1'b1;
        bus.slowValid_i = 1'b0;
      end
      chk("drain.tag", 64'(bus.bypassPacket_o.tag), 64'(20 + k));
    end
    chk("fifth.accepted", 64'(got), 64'd1);
    idle();
    step("drain_end", acc);

    // Squash with buffered entries plus fast and slow offers
    for (int i = 0; i < 2; i++) begin
      bus.fastValid_i = 1'b1;
      bus.fastTag_i   = 7'(110 + i);
      bus.fastData_i  = $urandom;
      bus.slowValid_i = 1'b1;
      bus.slowTag_i   = 7'(40 + i);
      bus.slowData_i  = $urandom;
      step("sq_fill", acc);
    end
    bus.squash_i    = 1'b1;
    bus.fastTag_i   = 7'd50;
    bus.slowTag_i   = 7'd42;
    step("squash", acc);
    chk("squash.valid0", 64'(bus.bypassPacket_o.valid), 64'd0);
    chk("squash.occ0", 64'(bus.occupancy_o), 64'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step("post_sq", acc);
      chk("post_sq.valid0", 64'(bus.bypassPacket_o.valid), 64'd0);
    end

    // Asynchronous reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      bus.fastValid_i = 1'b1;
      bus.fastTag_i   = 7'(120 + i);
      bus.fastData_i  = $urandom;
      bus.slowValid_i = 1'b1;
      bus.slowTag_i   = 7'(60 + i);
      bus.slowData_i  = $urandom;
      step("rst_fill", acc);
    end
    idle();
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("mid_rst.pkt", 64'(bus.bypassPacket_o), 64'h0);
    chk("mid_rst.occ", 64'(bus.occupancy_o), 64'd0);
    chk("mid_rst.rdy", 64'(bus.slowReady_o), 64'd1);
    #2 reset = 1'b1;
    step("post_rst", acc);
    step("post_rst", acc);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.squash_i    = ($urandom_range(0, 19) == 0);
      bus.fastValid_i = $urandom_range(0, 1) == 1;
      bus.fastTag_i   = 7'($urandom);
      bus.fastData_i  = $urandom;
      bus.slowValid_i = ($urandom_range(0, 9) < 6);
      bus.slowTag_i   = 7'($urandom);
      bus.slowData_i  = $urandom;
      step("rand", acc);
    end
    idle();
    for (int i = 0; i < 6; i++) step("rand_drain", acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bypass_lane_driver.md
# bypass_lane_driver

Producer side of one issue lane's bypass network: collects completed results from that lane's execution units and drives exactly one registered bypass packet per cycle onto the lane's slot of the `bypassPacket` bus that every source-operand bypass mux compares against. A fixed-latency (single-cycle, non-stallable) result has priority. Variable-latency results (load/multiply) are buffered in a small FIFO and drained into idle slots under a valid/ready handshake. Sits between the lane's execute stage and the register-read bypass muxes / register-file write port.

## Interface
- `SIZE_PHYSICAL_LOG`, 7, physical register tag width
- `SIZE_DATA`, 32, result data width
- `Q_DEPTH`, 4, slow-result FIFO entries (power of two, ≥2)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `squash_i`  in  1  pipeline flush; discards all buffered and incoming results
- `fastValid_i`  in  1  fixed-latency result present this cycle
- `fastTag_i`  in  `SIZE_PHYSICAL_LOG`  destination physical tag
- `fastData_i`  in  `SIZE_DATA`  result value
- `slowValid_i`  in  1  variable-latency result offered
- `slowReady_o`  out  1  FIFO can accept; transfer occurs when valid && ready
- `slowTag_i`  in  `SIZE_PHYSICAL_LOG`  destination physical tag
- `slowData_i`  in  `SIZE_DATA`  result value
- `bypassPacket_o`  out  `bypassPkt` (valid, tag, data; 1+`SIZE_PHYSICAL_LOG`+`SIZE_DATA`)  registered bypass slot
- `occupancy_o`  out  clog2(`Q_DEPTH`)+1  current FIFO entry count

## Operation
- Each cycle selects at most one result for the output register:
  - If `fastValid_i`=1, the fast result is selected.
  - Else, if the FIFO is non-empty, the FIFO head is selected and dequeued.
  - Else, the output is an invalid packet.
- Slow path always goes through the FIFO; there is no direct slow→output path.
- `slowReady_o` = (registered count < `Q_DEPTH`). It has no combinational dependence on any input. When full, it stays 0 even in a cycle that also dequeues.
- Enqueue and dequeue may occur in the same cycle. The count is then unchanged, and the pointers each advance by one modulo `Q_DEPTH`.
- Order is preserved among slow results. Fast results may overtake buffered slow results.
- `squash_i`=1 in cycle k:
  - Clears the FIFO at edge k (count and pointers go to 0).
  - Any fast or slow input in cycle k is dropped.
  - The output packet in cycle k+1 has valid=0.
  - The squash takes priority over all other events.
- Invalid output packets drive tag=0 and data=0, so consumers cannot false-match on stale tags.
- Reset (async, while `reset`=0):
  - `bypassPacket_o` = {0,0,0}.
  - Count, head pointer and tail pointer = 0.
  - `slowReady_o`=1.
  - Assertion mid-operation discards all contents immediately.

## Timing
- Fast: valid in cycle k → on `bypassPacket_o` in cycle k+1 (1-cycle latency, unconditional).
- Slow: accepted in cycle k → earliest on output in cycle k+2. Each cycle with `fastValid_i`=1 adds one further cycle.
- `occupancy_o` reflects state after the previous edge.
- Starvation: a continuous fast stream holds slow results indefinitely. The upstream scheduler guarantees gaps; this block does not arbitrate fairly.
- Output packet is held for exactly one cycle. There is no backpressure from consumers.

## Structure
- The `bypassPkt` typedef (valid, tag, data) and the `SIZE_PHYSICAL_LOG`/`SIZE_DATA` defaults belong in the shared core package, common with the bypass consumers.
- Sub-module `bypass_result_fifo`: a parameterized `Q_DEPTH` circular buffer. It has push/pop/clear inputs, head outputs, and count and full/empty flags, and uses the same async active-low reset.
- The top level holds the select logic and the output register.

## Test plan
- Reset, then fast valid tag=5 data=0xAAAA in cycle 1 → cycle 2 packet {1,5,0xAAAA}; cycle 3 packet {0,0,0}.
- Slow tag=9 data=0x1234 accepted in cycle 1, no fast traffic → cycle 3 packet {1,9,0x1234}; `occupancy_o` is 1 in cycle 2 and 0 in cycle 3.
- Fast valid held in cycles 1–5 while four slow results (tags 20–23) are offered → all four accepted and `slowReady_o`=0 from cycle 5. A fifth slow offer is not accepted until a slot frees. After fast stops, tags 20,21,22,23 emerge in order on consecutive cycles.
- Full FIFO with simultaneous dequeue and new slow offer → offer not accepted that cycle; `slowReady_o`=1 next cycle with count 3.
- Two entries buffered, `squash_i` in cycle k together with fast valid and slow valid → packet invalid in cycle k+1, count 0, nothing from before the squash ever appears.
- `reset` pulled low mid-drain with three entries → output immediately {0,0,0}, count 0, `slowReady_o`=1.
